// File: rtl/key_sweep_ctrl_if.sv
// rtl/key_sweep_ctrl_if.sv - harness and locked/golden netlist signals of the key sweep controller
interface key_sweep_ctrl_if #(
    parameter int PI_W = 36,
    parameter int PO_W = 7
);
    logic            start;
    logic            busy;
    logic            done;
    logic [1:0]      key;
    logic [PI_W-1:0] pi;
    logic [PO_W-1:0] dut_po;
    logic [PO_W-1:0] oracle_po;
    logic [2:0]      alive;
    // "unique" is a reserved word, so the single-survivor flag is called uniq
    logic            uniq;

    modport master (
        input  start, dut_po, oracle_po,
        output busy, done, key, pi, alive, uniq
    );

    modport slave (
        output start, dut_po, oracle_po,
        input  busy, done, key, pi, alive, uniq
    );
endinterface

// File: rtl/key_sweep_ctrl.sv
// rtl/key_sweep_ctrl.sv - sweeps the allowed key codes over a locked netlist and tracks surviving keys
module key_sweep_ctrl #(
    parameter int          PI_W   = 36,
    parameter int          NPAT   = 16,
    parameter int          SETTLE = 2,
    parameter logic [35:0] SEED   = 36'h0_0000_0001
) (
    input logic             clk,
    input logic             rst,
    key_sweep_ctrl_if.master bus
);
    localparam int IDX_W = (NPAT > 1) ? $clog2(NPAT) : 1;
    localparam int CNT_W = $clog2(SETTLE + 1);
    // an all-zero LFSR would lock up, so a zero seed is replaced by 1
    localparam logic [35:0]      SEED_EFF = (SEED == 36'd0) ? 36'd1 : SEED;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPAT - 1);
    localparam logic [CNT_W-1:0] SETTLE_V = CNT_W'(SETTLE);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_APPLY, S_WAIT, S_CHECK, S_NEXT, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       key_q, key_d;
    logic [2:0]       alive_q, alive_d;
    logic [35:0]      lfsr_q, lfsr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PI_W-1:0]  pi_q, pi_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic        mismatch;
    logic        last_pat;
    logic [35:0] lfsr_next;

    assign mismatch  = (bus.dut_po != bus.oracle_po);
    assign last_pat  = (idx_q == LAST_IDX);
    // x^36 + x^11 + 1, shifting left with the feedback entering bit 0
    assign lfsr_next = {lfsr_q[34:0], lfsr_q[35] ^ lfsr_q[10]};

    // state and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            key_q   <= 2'b00;
            alive_q <= 3'b111;
            lfsr_q  <= SEED_EFF;
            idx_q   <= '0;
            cnt_q   <= '0;
            pi_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            alive_q <= alive_d;
            lfsr_q  <= lfsr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pi_q    <= pi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // next-state decode; start only matters in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_LOAD;
            S_LOAD:  state_d = S_APPLY;
            S_APPLY: state_d = S_WAIT;
            S_WAIT:  if (cnt_q <= CNT_W'(1)) state_d = S_CHECK;
            S_CHECK: state_d = (mismatch || last_pat) ? S_NEXT : S_APPLY;
            S_NEXT:  state_d = (key_q == 2'b10) ? S_DONE : S_LOAD;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // register next values; busy/done follow the state being entered so they are registered
    always_comb begin
        key_d   = key_q;
        alive_d = alive_q;
        lfsr_d  = lfsr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pi_d    = pi_q;
        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d  = (state_d == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    alive_d = 3'b111;
                    key_d   = 2'b00;
                end
            end
            S_LOAD: begin
                lfsr_d = SEED_EFF;
                idx_d  = '0;
            end
            S_APPLY: begin
                pi_d  = PI_W'(lfsr_q);
                cnt_d = SETTLE_V;
            end
            S_WAIT: cnt_d = cnt_q - CNT_W'(1);
            S_CHECK: begin
                if (mismatch) begin
                    alive_d = alive_q & ~(3'b001 << key_q);
                end else if (!last_pat) begin
                    lfsr_d = lfsr_next;
                    idx_d  = idx_q + IDX_W'(1);
                end
            end
            S_NEXT: if (key_q != 2'b10) key_d = key_q + 2'b01;
            default: ;
        endcase
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.key   = key_q;
    assign bus.pi    = pi_q;
    assign bus.alive = alive_q;
    assign bus.uniq  = (alive_q == 3'b001) || (alive_q == 3'b010) || (alive_q == 3'b100);
endmodule

// File: tb/tb_key_sweep_ctrl.sv
// tb/tb_key_sweep_ctrl.sv - randomized self-checking bench for key_sweep_ctrl against a schedule model
module tb_key_sweep_ctrl;
    localparam int PI_W   = 36;
    localparam int PO_W   = 7;
    localparam int NPAT   = 4;
    localparam int SETTLE = 2;
    localparam int MAXC   = 128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_sweep_ctrl_if #(.PI_W(PI_W), .PO_W(PO_W)) bus ();

    key_sweep_ctrl #(
        .PI_W(PI_W), .NPAT(NPAT), .SETTLE(SETTLE), .SEED(36'h1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    logic [35:0] pat [NPAT];
    int          fail_idx [3];
    logic [6:0]  salt;
    logic [6:0]  flip;

    logic [35:0] e_pi   [MAXC];
    logic [1:0]  e_key  [MAXC];
    logic        e_busy [MAXC];
    logic        e_done [MAXC];
    int          n_tr;
    logic [35:0] cur_pi;

    // locked-netlist stand-in: matches the golden twin except on the chosen (key, pattern) pair
    always_comb begin
        logic [6:0] gold;
        gold = bus.pi[6:0] ^ salt;
        bus.oracle_po = gold;
        bus.dut_po    = gold;
        for (int k = 0; k < 3; k++) begin
            if (bus.key == 2'(k) && fail_idx[k] < NPAT && bus.pi == pat[fail_idx[k]])
                bus.dut_po = gold ^ flip;
        end
    end

    function automatic logic [35:0] lfsr_step(input logic [35:0] x);
        return {x[34:0], x[35] ^ x[10]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [35:0] p, input logic [1:0] k, input logic b, input logic d);
        e_pi[n_tr]   = p;
        e_key[n_tr]  = k;
        e_busy[n_tr] = b;
        e_done[n_tr] = d;
        n_tr++;
    endtask

    // expected cycle-by-cycle outputs of one sweep; index 1 is the cycle after start is taken
    task automatic build_trace();
        int last;
        n_tr = 1;
        for (int k = 0; k < 3; k++) begin
            push(cur_pi, 2'(k), 1'b1, 1'b0);
            last = (fail_idx[k] < NPAT) ? fail_idx[k] : NPAT - 1;
            for (int p = 0; p <= last; p++) begin
                push(cur_pi, 2'(k), 1'b1, 1'b0);
                cur_pi = pat[p];
                repeat (SETTLE + 1) push(cur_pi, 2'(k), 1'b1, 1'b0);
            end
            push(cur_pi, 2'(k), 1'b1, 1'b0);
        end
        push(cur_pi, 2'b10, 1'b0, 1'b1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".busy"},  64'(bus.busy),  64'(1'b0));
        chk({tag, ".done"},  64'(bus.done),  64'(1'b0));
        chk({tag, ".key"},   64'(bus.key),   64'(2'b00));
        chk({tag, ".pi"},    64'(bus.pi),    64'(36'h0));
        chk({tag, ".alive"}, 64'(bus.alive), 64'(3'b111));
        chk({tag, ".uniq"},  64'(bus.uniq),  64'(1'b0));
    endtask

    task automatic sweep(input string tag, input int restart_at, input int abort_at);
        logic [2:0] exp_alive;
        int         nalive;
        build_trace();
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 1; c < n_tr; c++) begin
            if (c == abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                chk_reset_vals({tag, ".abort"});
                cur_pi = '0;
                return;
            end
            chk({tag, ".busy"}, 64'(bus.busy), 64'(e_busy[c]));
            chk({tag, ".done"}, 64'(bus.done), 64'(e_done[c]));
            chk({tag, ".key"},  64'(bus.key),  64'(e_key[c]));
            chk({tag, ".pi"},   64'(bus.pi),   64'(e_pi[c]));
            if (c == restart_at || c == n_tr - 1) bus.start = 1'b1;
            @(posedge clk);
            #1 bus.start = 1'b0;
        end
        chk({tag, ".idle_busy"}, 64'(bus.busy), 64'(1'b0));
        chk({tag, ".idle_done"}, 64'(bus.done), 64'(1'b0));
        @(posedge clk);
        #1;
        chk({tag, ".idle2_busy"}, 64'(bus.busy), 64'(1'b0));
        exp_alive = 3'b000;
        nalive    = 0;
        for (int k = 0; k < 3; k++) begin
            if (fail_idx[k] >= NPAT) begin
                exp_alive[k] = 1'b1;
                nalive++;
            end
        end
        chk({tag, ".alive"}, 64'(bus.alive), 64'(exp_alive));
        chk({tag, ".uniq"},  64'(bus.uniq),  64'(nalive == 1));
        chk({tag, ".key_hold"}, 64'(bus.key), 64'(2'b10));
    endtask

    initial begin
        pat[0] = 36'h1;
        for (int i = 1; i < NPAT; i++) pat[i] = lfsr_step(pat[i-1]);
        for (int k = 0; k < 3; k++) fail_idx[k] = NPAT;
        salt      = 7'h00;
        flip      = 7'h01;
        cur_pi    = '0;
        bus.start = 1'b0;
        rst       = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");

        @(negedge clk) bus.start = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_vs_start.busy", 64'(bus.busy), 64'(1'b0));
        rst       = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_vs_start.idle", 64'(bus.busy), 64'(1'b0));

        sweep("all_match", -1, -1);
        sweep("start_busy", 10, -1);

        fail_idx[0] = 0; fail_idx[1] = NPAT; fail_idx[2] = 3;
        salt = 7'h35; flip = 7'h40;
        sweep("survivor", -1, -1);

        for (int k = 0; k < 3; k++) fail_idx[k] = NPAT;
        sweep("mid_reset", -1, 25);
        sweep("after_reset", -1, -1);

        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 3; k++) fail_idx[k] = $urandom_range(0, NPAT);
            salt = 7'($urandom_range(0, 127));
            flip = 7'($urandom_range(1, 127));
            sweep($sformatf("rand%0d", r), $urandom_range(2, 15), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
